// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path (and the future transmitter):
//   rx_state_e  - receiver frame state
//   PAR_*       - parity mode encodings for the PARITY parameter
//   baud_div()  - clocks per oversample tick, rounded to nearest
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Round-to-nearest so the tick rate error is at most half a clock per tick.
  function automatic int baud_div(input int clk_hz, input int baud, input int oversample);
    return (clk_hz + (baud * oversample) / 2) / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Received-word handshake between the UART receiver and its consumer.
//   out_data    received word (LSB first on the line)
//   out_valid   holding register full
//   out_ready   consumer accepts when out_valid && out_ready
//   frame_err   held frame had a low stop bit
//   parity_err  held frame failed parity
//   overrun     at least one frame dropped while this one was held
// master: the receiver; slave: the consumer.
// ---------------------------------------------------------------------------
interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output out_data, out_valid, frame_err, parity_err, overrun,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, frame_err, parity_err, overrun,
    output out_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider producing a one-clock tick every DIV clocks.
//   clock    system clock
//   rst      asynchronous active-low reset
//   clear_i  synchronous restart; the next tick follows DIV clocks later
//   tick_o   one-clock pulse per oversample period
// ---------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int DIV = 15
) (
  input  logic clock,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear_i || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Suppressed on clear so a restart never emits a stale tick.
  assign tick_o = (cnt_q == LAST) && !clear_i;

endmodule

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// Parametrised UART receiver: 16x (OVERSAMPLE) sampling with 3-sample
// majority vote, start-glitch rejection, optional parity, 1 or 2 stop bits,
// break handling, and a one-entry holding register with overrun flag.
//   clock   system clock, all logic on posedge
//   rst     asynchronous active-low reset
//   rx      asynchronous serial line, idle high
//   busy    frame in progress (state != IDLE)
//   out_if  received word + error flags, valid/ready handshake
// ---------------------------------------------------------------------------
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic      clock,
  input  logic      rst,
  input  logic      rx,
  output logic      busy,
  uart_rx_if.master out_if
);

  localparam int            DIV   = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int            M     = OVERSAMPLE / 2;
  localparam int            PW    = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PH_S0   = PW'(M - 1);
  localparam logic [PW-1:0] PH_S1   = PW'(M);
  localparam logic [PW-1:0] PH_S2   = PW'(M + 1);

  rx_state_e state_q, state_d;

  logic [1:0]           sync_q;
  logic                 rxs;
  logic                 armed_q;
  logic [PW-1:0]        phase_q, phase_nx;
  logic [1:0]           vote_q;
  logic                 maj;
  logic [DATA_BITS-1:0] shreg_q;
  logic [3:0]           bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 stop_low_q;
  logic                 par_err_q;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, frame_err_q, parity_err_q, overrun_q;

  logic tick, start_edge, samp0, samp1, decide, bit_end, last_stop, frame_done;

  // -------------------------------------------------------------------------
  // Synchroniser; reset to the idle level so reset never looks like a start.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], rx};
  end
  assign rxs = sync_q[1];

  assign start_edge = (state_q == ST_IDLE) && !rxs && armed_q;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clock   (clock),
    .rst     (rst),
    .clear_i (start_edge),
    .tick_o  (tick)
  );

  assign phase_nx  = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
  assign samp0     = tick && (phase_nx == PH_S0);
  assign samp1     = tick && (phase_nx == PH_S1);
  assign decide    = tick && (phase_nx == PH_S2);
  assign bit_end   = tick && (phase_q == PH_LAST);
  assign maj       = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);
  assign last_stop = (STOP_BITS == 1) || stop_cnt_q;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // NOTE: the default assignment first means every path assigns state_d,
  // so no latch is inferred.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_edge) state_d = ST_START;
      ST_START: begin
        if (decide && maj) state_d = ST_IDLE;      // glitch, not a real start
        else if (bit_end)  state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && bit_cnt_q == 4'(DATA_BITS))
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP: begin
        // Finish at the deciding sample to re-arm half a bit early.
        if (decide && last_stop)
          state_d = (!maj && shreg_q == '0) ? ST_BREAK : ST_IDLE;
      end
      ST_BREAK:  if (rxs) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy       = (state_q != ST_IDLE);
    frame_done = (state_q == ST_STOP) && decide && last_stop;
  end

  // -------------------------------------------------------------------------
  // Bit timing, voting and frame assembly
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      armed_q    <= 1'b0;
      phase_q    <= '0;
      vote_q     <= 2'b11;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      stop_low_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      // Arming only in IDLE with the line high keeps a held-low line (break,
      // low stop bit) from starting phantom frames.
      if (start_edge)                     armed_q <= 1'b0;
      else if (state_q == ST_IDLE && rxs) armed_q <= 1'b1;

      if (start_edge) phase_q <= '0;
      else if (tick)  phase_q <= phase_nx;

      if (samp0) vote_q[0] <= rxs;
      if (samp1) vote_q[1] <= rxs;

      if (start_edge) begin
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        stop_low_q <= 1'b0;
        par_err_q  <= 1'b0;
      end else if (decide) begin
        unique case (state_q)
          ST_DATA: begin
            shreg_q   <= {maj, shreg_q[DATA_BITS-1:1]};  // LSB arrives first
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          ST_PARITY: par_err_q  <= ((^shreg_q) ^ maj) != (PARITY == PAR_ODD);
          ST_STOP:   if (!maj) stop_low_q <= 1'b1;
          default: ;
        endcase
      end else if (bit_end && state_q == ST_STOP) begin
        stop_cnt_q <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Holding register and handshake
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (frame_done) begin
      if (!valid_q || out_if.out_ready) begin
        data_q       <= shreg_q;
        valid_q      <= 1'b1;
        frame_err_q  <= stop_low_q | !maj;
        parity_err_q <= par_err_q;
        overrun_q    <= 1'b0;
      end else begin
        overrun_q    <= 1'b1;                       // new frame dropped
      end
    end else if (valid_q && out_if.out_ready) begin
      valid_q <= 1'b0;                              // flags hold until next load
    end
  end

  assign out_if.out_data   = data_q;
  assign out_if.out_valid  = valid_q;
  assign out_if.frame_err  = frame_err_q;
  assign out_if.parity_err = parity_err_q;
  assign out_if.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
// Two receivers (8N1 and 8E1) on separate lines. Stimulus tasks push the
// expected word/flags into a per-receiver queue as each frame is sent; a
// monitor per receiver pops and compares whenever a word is accepted.
// ---------------------------------------------------------------------------
module tb_uart_rx_core;

  localparam int CLK_HZ = 27000000;
  localparam int BAUD   = 115200;
  localparam int OS     = 16;
  // Bit time as the receiver sees it: round(CLK_HZ / (BAUD*16)) = 15 clocks/tick.
  localparam int BITC   = 15 * OS;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       ov;
  } exp_t;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  logic rx_n  = 1'b1;
  logic rx_e  = 1'b1;
  logic busy_n, busy_e;

  uart_rx_if #(.DATA_BITS(8)) bus_n ();
  uart_rx_if #(.DATA_BITS(8)) bus_e ();

  uart_rx_core #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_n (
    .clock (clock), .rst (rst), .rx (rx_n), .busy (busy_n), .out_if (bus_n)
  );

  uart_rx_core #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)
  ) dut_e (
    .clock (clock), .rst (rst), .rx (rx_e), .busy (busy_e), .out_if (bus_e)
  );

  always #5 clock = ~clock;

  exp_t q_n[$];
  exp_t q_e[$];
  exp_t got_n, got_e, exp_n, exp_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Monitors: one comparison per accepted word.
  // -------------------------------------------------------------------------
  always @(negedge clock) begin
    if (rst && bus_n.out_valid && bus_n.out_ready) begin
      got_n = {bus_n.out_data, bus_n.frame_err, bus_n.parity_err, bus_n.overrun};
      if (q_n.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_n: got %0h expected no word", got_n);
      end else begin
        exp_n = q_n.pop_front();
        check("frame_n", 32'(got_n), 32'(exp_n));
      end
    end
  end

  always @(negedge clock) begin
    if (rst && bus_e.out_valid && bus_e.out_ready) begin
      got_e = {bus_e.out_data, bus_e.frame_err, bus_e.parity_err, bus_e.overrun};
      if (q_e.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_e: got %0h expected no word", got_e);
      end else begin
        exp_e = q_e.pop_front();
        check("frame_e", 32'(got_e), 32'(exp_e));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Line drivers. Inputs change 1 time unit after a rising edge.
  // -------------------------------------------------------------------------
  task automatic drive(input bit which, input logic v, input int clks);
    if (which) rx_e = v;
    else       rx_n = v;
    repeat (clks) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int clks);
    repeat (clks) @(posedge clock);
    #1;
  endtask

  // which=0: 8N1 line; which=1: 8E1 line (pbit is the parity bit sent).
  task automatic send_frame(input bit which, input logic [7:0] data, input logic pbit,
                            input bit stop_low, input int bclk, input bit push);
    exp_t e;
    int   ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(data[i]);
    e.data = data;
    e.fe   = stop_low;
    // Even parity: the data ones plus the parity bit must total an even count.
    e.pe   = which ? (((ones + int'(pbit)) % 2) == 1) : 1'b0;
    e.ov   = 1'b0;
    if (push) begin
      if (which) q_e.push_back(e);
      else       q_n.push_back(e);
    end
    drive(which, 1'b0, bclk);
    for (int i = 0; i < 8; i++) drive(which, data[i], bclk);
    if (which) drive(which, pbit, bclk);
    drive(which, !stop_low, bclk);
    if (which) rx_e = 1'b1;
    else       rx_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [7:0] rd_n, rd_e;
  logic       rp_e;
  bit         sl_n, sl_e;
  int         bc_n, bc_e;

  initial begin
    bus_n.out_ready = 1'b1;
    bus_e.out_ready = 1'b1;
    idle(3);

    // Reset values
    check("rst_valid", 32'(bus_n.out_valid), 32'd0);
    check("rst_data",  32'(bus_n.out_data),  32'd0);
    check("rst_flags", 32'({bus_n.frame_err, bus_n.parity_err, bus_n.overrun}), 32'd0);
    check("rst_busy",  32'(busy_n),          32'd0);
    rst = 1'b1;
    idle(2 * BITC);

    // Clean 8N1 frame
    send_frame(0, 8'hA5, 1'b0, 1'b0, BITC, 1'b1);
    idle(2 * BITC);

    // 8E1: 0x3C has four ones, so parity bit 1 is wrong and 0 is right
    send_frame(1, 8'h3C, 1'b1, 1'b0, BITC, 1'b1);
    send_frame(1, 8'h3C, 1'b0, 1'b0, BITC, 1'b1);
    idle(2 * BITC);

    // Low stop bit
    send_frame(0, 8'h55, 1'b0, 1'b1, BITC, 1'b1);
    idle(2 * BITC);

    // Two-frame break: one zero word with frame_err, then silence
    q_n.push_back('{data: 8'h00, fe: 1'b1, pe: 1'b0, ov: 1'b0});
    drive(0, 1'b0, 15 * BITC);
    check("break_busy", 32'(busy_n), 32'd1);
    drive(0, 1'b0, 5 * BITC);
    rx_n = 1'b1;
    idle(3 * BITC);
    check("break_idle", 32'(busy_n), 32'd0);

    // 5-clock glitch on an idle line
    drive(0, 1'b0, 5);
    rx_n = 1'b1;
    idle(20);
    check("glitch_busy", 32'(busy_n), 32'd1);
    idle(300);
    check("glitch_idle",  32'(busy_n),          32'd0);
    check("glitch_valid", 32'(bus_n.out_valid), 32'd0);
    idle(BITC);

    // Back-to-back frames with the consumer stalled
    bus_n.out_ready = 1'b0;
    q_n.push_back('{data: 8'h11, fe: 1'b0, pe: 1'b0, ov: 1'b1});
    send_frame(0, 8'h11, 1'b0, 1'b0, BITC, 1'b0);
    send_frame(0, 8'h22, 1'b0, 1'b0, BITC, 1'b0);
    send_frame(0, 8'h33, 1'b0, 1'b0, BITC, 1'b0);
    idle(BITC);
    check("ovr_valid", 32'(bus_n.out_valid), 32'd1);
    check("ovr_data",  32'(bus_n.out_data),  32'h11);
    check("ovr_flag",  32'(bus_n.overrun),   32'd1);
    bus_n.out_ready = 1'b1;
    idle(1);
    bus_n.out_ready = 1'b0;
    check("ovr_accepted",  32'(bus_n.out_valid), 32'd0);
    check("ovr_flag_hold", 32'(bus_n.overrun),   32'd1);
    idle(2);
    bus_n.out_ready = 1'b1;
    idle(BITC);

    // Reset in the middle of the data bits of 0x77
    drive(0, 1'b0, BITC);
    for (int i = 0; i < 4; i++) drive(0, (8'h77 >> i) & 8'h01, BITC);
    rst = 1'b0;
    #1;
    check("midrst_busy",  32'(busy_n),          32'd0);
    check("midrst_valid", 32'(bus_n.out_valid), 32'd0);
    check("midrst_data",  32'(bus_n.out_data),  32'd0);
    rx_n = 1'b1;
    idle(3);
    rst = 1'b1;
    idle(2 * BITC);
    send_frame(0, 8'h88, 1'b0, 1'b0, BITC, 1'b1);
    idle(2 * BITC);

    // Randomised traffic on both lines, bit time within about +/-3% of nominal
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          rd_n = 8'($urandom);
          sl_n = ($urandom_range(0, 7) == 0);
          bc_n = $urandom_range(232, 248);
          send_frame(0, rd_n, 1'b0, sl_n, bc_n, 1'b1);
          if (sl_n) drive(0, 1'b1, 2 * bc_n);
          else if ($urandom_range(0, 1) == 1) drive(0, 1'b1, $urandom_range(1, 300));
        end
      end
      begin
        for (int k = 0; k < 10; k++) begin
          rd_e = 8'($urandom);
          rp_e = 1'($urandom);
          sl_e = ($urandom_range(0, 7) == 0);
          bc_e = $urandom_range(232, 248);
          send_frame(1, rd_e, rp_e, sl_e, bc_e, 1'b1);
          if (sl_e) drive(1, 1'b1, 2 * bc_e);
          else if ($urandom_range(0, 1) == 1) drive(1, 1'b1, $urandom_range(1, 300));
        end
      end
    join

    // Let the last words drain, bounded
    for (int t = 0; t < 4 * BITC && (q_n.size() != 0 || q_e.size() != 0); t++)
      @(posedge clock);
    idle(2);
    check("drain_n", 32'(q_n.size()), 32'd0);
    check("drain_e", 32'(q_e.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receiver; successor to the fixed 8N1 receiver. Adds configurable baud/clock, data width, parity and stop bits, 16x oversampling with 3-sample majority vote, start-bit glitch rejection, per-frame error flags, and a valid/ready output with a one-entry holding register and overrun detection. Sits between the board `rx` pin and the command parser in the UART return path.

## Interface
- `CLK_HZ`, 27000000, system clock frequency.
- `BAUD`, 115200, line rate.
- `OVERSAMPLE`, 16, ticks per bit; even, ≥8.
- `DATA_BITS`, 8, data bits per frame, 5..8.
- `PARITY`, 0, parity mode: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1, stop bits checked, 1 or 2.
- `clock`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset: asynchronous, active-low.
- `rx`  in  1  asynchronous serial line, idle high.
- `out_data`  out  DATA_BITS  received word, LSB first on line; reset 0.
- `out_valid`  out  1  holding register full; reset 0.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `frame_err`  out  1  held frame had a low stop bit; reset 0.
- `parity_err`  out  1  held frame failed parity (0 when PARITY=0); reset 0.
- `overrun`  out  1  at least one frame dropped while this one was held; reset 0.
- `busy`  out  1  frame in progress (state ≠ IDLE); reset 0.

## Operation
- `rx` passes a 2-flop synchroniser, both flops reset to 1; all logic uses the synchronised value `rxs`.
- Tick divider: `DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE)` (rounded; 15 at defaults); `tick` pulses one clock every DIV clocks. Divider and phase counter clear on start-edge detection, so sampling is aligned to the edge.
- Phase counter 0..OVERSAMPLE-1 per bit; samples taken at phases M-1, M, M+1 (M = OVERSAMPLE/2); bit value = majority of the three, decided at phase M+1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: `rxs`=0 and armed -> START. Armed only after `rxs` seen 1 at least one clock.
  - START: majority 1 -> IDLE (glitch, nothing delivered); majority 0 -> DATA at end of bit.
  - DATA: shift in DATA_BITS bits LSB first; -> PARITY if PARITY≠0, else STOP.
  - PARITY: error if (XOR of data ^ parity bit) ≠ (PARITY==2).
  - STOP: each of STOP_BITS checked; any low -> frame_err. Decision at phase M+1 of last stop bit; completes frame immediately (no wait to end of bit). Low last stop and all data 0 -> BREAK, else -> IDLE.
  - BREAK: wait for `rxs`=1, then IDLE (disarm prevents spurious frames during break).
- Completion: if holding empty, or accept in the same clock, load data and flags, `out_valid`=1, `overrun`=0. If full and not accepted: frame dropped, held data untouched, `overrun` set to 1.
- Errored frames are still delivered with flags set.
- Accept without completion: `out_valid`=0; flag outputs hold until next load.
- Reset mid-frame: everything returns to reset values immediately; partial frame discarded.

## Timing
- Completion -> `out_valid` high: 1 clock after the deciding last-stop-bit sample.
- Outputs registered; `out_data`/flags stable while `out_valid`=1 and not accepted.
- Re-arm after a normal frame is ≈½ bit before nominal frame end, tolerating ±4% baud mismatch back-to-back.
- `out_ready` may be held high permanently; throughput one frame per frame time, no bubbles.

## Structure
- Package `uart_pkg`: state enum, parity mode constants (PAR_NONE/EVEN/ODD), divider rounding function.
- Sub-module `uart_baud_tick` (divider with synchronous clear, `tick` output); shared with the future transmitter.

## Test plan
- 0xA5, 8N1, 115200 at 27 MHz, `out_ready`=1 -> `out_data`=0xA5, one-clock `out_valid`, all flags 0.
- 0x3C, 8E1, parity bit sent 1 -> `out_data`=0x3C, `parity_err`=1; same with parity bit 0 -> no error.
- 0x55, stop bit driven low -> `frame_err`=1, data 0x55; full 2-frame break -> one frame_err frame, data 0, no further frames until line high.
- 5-clock low glitch on idle line -> no `out_valid`, `busy` returns 0 within ~1 bit.
- Frames 0x11, 0x22, 0x33 back-to-back with `out_ready`=0 -> held 0x11 with `overrun`=1; after accept, `out_valid`=0.
- `rst` asserted mid-DATA of 0x77, released, then 0x88 sent -> only 0x88 delivered, no flags.
